batalha_rodadas: RTL and testbench

- Multi-round, clocked successor to the combinational code-battle checker.
- Player A commits a W-bit code; player B then guesses it. B hits when the guess equals the bitwise complement of A's code.
- Codes that are all-zeros or all-ones are illegal and rejected.
- The block sequences ROUNDS rounds, keeps per-player scores, supports early termination on an unassailable lead, and reports the winner.

---
 rtl/batalha_rodadas_if.sv | 38 +++
 rtl/batalha_rodadas.sv | 148 ++++++++++++++
 tb/tb_batalha_rodadas.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/batalha_rodadas_if.sv
// Port bundle for batalha_rodadas: game control, the two player handshakes,
// round results, scores and the FSM state for debug visibility.
interface batalha_rodadas_if #(
  parameter int W      = 3,
  parameter int ROUNDS = 5
);
  localparam int CW = $clog2(ROUNDS + 1);

  logic          start;
  logic [W-1:0]  ja;
  logic          ja_valid;
  logic          ja_ready;
  logic [W-1:0]  jb;
  logic          jb_valid;
  logic          jb_ready;
  logic          err_a;
  logic          err_b;
  logic          res_valid;
  logic          res_hit;
  logic [CW-1:0] score_a;
  logic [CW-1:0] score_b;
  logic [CW-1:0] round;
  logic          done;
  logic [1:0]    winner;
  logic [2:0]    state_dbg;

  modport master (
    output start, ja, ja_valid, jb, jb_valid,
    input  ja_ready, jb_ready, err_a, err_b, res_valid, res_hit,
           score_a, score_b, round, done, winner, state_dbg
  );

  modport slave (
    input  start, ja, ja_valid, jb, jb_valid,
    output ja_ready, jb_ready, err_a, err_b, res_valid, res_hit,
           score_a, score_b, round, done, winner, state_dbg
  );
endinterface

// File: rtl/batalha_rodadas.sv
// Multi-round code battle: A commits a code, B guesses its complement; the
// block judges each round, keeps scores, ends early on a decisive lead.
module batalha_rodadas #(
  parameter int W         = 3,
  parameter int ROUNDS    = 5,
  parameter int EARLY_END = 1
) (
  input  logic               clk,
  input  logic               rst,
  batalha_rodadas_if.slave   bus
);
  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] ROUNDS_C = CW'(ROUNDS);
  localparam logic [CW-1:0] HALF_C   = CW'(ROUNDS / 2);
  localparam logic [W-1:0]  ONES     = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_A = 3'd1,
    WAIT_B = 3'd2,
    JUDGE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q;
  logic [CW-1:0] sa_q, sb_q, rd_q;
  logic [CW-1:0] sa_n, sb_n, rd_n;
  logic          err_a_q, err_b_q, res_valid_q, res_hit_q, done_q;
  logic [1:0]    winner_q;

  logic ja_ill, jb_ill, hit_j, fin;
  logic acc_a, acc_b, rej_a, rej_b, clr_game;

  assign ja_ill = (bus.ja == '0) || (bus.ja == ONES);
  assign jb_ill = (bus.jb == '0) || (bus.jb == ONES);

  // Outcome of the round being judged, and the counters it produces.
  assign hit_j = (b_q == ~a_q);
  assign sa_n  = hit_j ? sa_q : sa_q + CW'(1);
  assign sb_n  = hit_j ? sb_q + CW'(1) : sb_q;
  assign rd_n  = rd_q + CW'(1);
  assign fin   = (rd_n == ROUNDS_C) ||
                 ((EARLY_END != 0) && ((sa_n > HALF_C) || (sb_n > HALF_C)));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Handshake: a word moves on any cycle with valid && ready; ready is a pure
  // state decode, valid may stay high, and an illegal word is consumed but
  // rejected (the state holds and an error pulse follows).
  always_comb begin
    state_d  = state_q;
    acc_a    = 1'b0;
    acc_b    = 1'b0;
    rej_a    = 1'b0;
    rej_b    = 1'b0;
    clr_game = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr_game = 1'b1;
          state_d  = WAIT_A;
        end
      end
      WAIT_A: begin
        if (bus.ja_valid) begin
          if (ja_ill) rej_a = 1'b1;
          else begin
            acc_a   = 1'b1;
            state_d = WAIT_B;
          end
        end
      end
      WAIT_B: begin
        if (bus.jb_valid) begin
          if (jb_ill) rej_b = 1'b1;
          else begin
            acc_b   = 1'b1;
            state_d = JUDGE;
          end
        end
      end
      JUDGE: state_d = fin ? DONE : WAIT_A;
      DONE: begin
        if (bus.start) begin
          clr_game = 1'b1;
          state_d  = WAIT_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      rd_q        <= '0;
      err_a_q     <= 1'b0;
      err_b_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      done_q      <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      err_a_q     <= rej_a;
      err_b_q     <= rej_b;
      res_valid_q <= acc_b;
      // Evaluated on the incoming guess so the strobe lands in the JUDGE cycle.
      res_hit_q   <= acc_b && (bus.jb == ~a_q);
      if (acc_a) a_q <= bus.ja;
      if (acc_b) b_q <= bus.jb;
      if (clr_game) begin
        sa_q     <= '0;
        sb_q     <= '0;
        rd_q     <= '0;
        done_q   <= 1'b0;
        winner_q <= 2'b00;
      end else if (state_q == JUDGE) begin
        sa_q <= sa_n;
        sb_q <= sb_n;
        rd_q <= rd_n;
        if (fin) begin
          done_q   <= 1'b1;
          winner_q <= (sa_n > sb_n) ? 2'b01 : (sb_n > sa_n) ? 2'b10 : 2'b11;
        end
      end
    end
  end

  assign bus.ja_ready  = (state_q == WAIT_A);
  assign bus.jb_ready  = (state_q == WAIT_B);
  assign bus.err_a     = err_a_q;
  assign bus.err_b     = err_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.score_a   = sa_q;
  assign bus.score_b   = sb_q;
  assign bus.round     = rd_q;
  assign bus.done      = done_q;
  assign bus.winner    = winner_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_batalha_rodadas.sv
// Bench for batalha_rodadas: two configurations (5 rounds with early end,
// 4 rounds played in full) share one stimulus stream and one game model.
module tb_batalha_rodadas;
  localparam int W  = 3;
  localparam int R0 = 5;
  localparam int E0 = 1;
  localparam int R1 = 4;
  localparam int E1 = 0;

  localparam int P_IDLE = 0;
  localparam int P_A    = 1;
  localparam int P_B    = 2;
  localparam int P_J    = 3;
  localparam int P_D    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start, ja_valid, jb_valid;
  logic [W-1:0] ja, jb;

  batalha_rodadas_if #(.W(W), .ROUNDS(R0)) bus0 ();
  batalha_rodadas_if #(.W(W), .ROUNDS(R1)) bus1 ();

  assign bus0.start = start;  assign bus1.start = start;
  assign bus0.ja = ja;        assign bus1.ja = ja;
  assign bus0.ja_valid = ja_valid;  assign bus1.ja_valid = ja_valid;
  assign bus0.jb = jb;        assign bus1.jb = jb;
  assign bus0.jb_valid = jb_valid;  assign bus1.jb_valid = jb_valid;

  batalha_rodadas #(.W(W), .ROUNDS(R0), .EARLY_END(E0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  batalha_rodadas #(.W(W), .ROUNDS(R1), .EARLY_END(E1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input int c, input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d.%s: got %0d, expected %0d", c, nm, act, exp);
    end
  endtask

  // ---------------- behavioural game model ----------------
  int           m_ph[2], m_sa[2], m_sb[2], m_rd[2], m_win[2];
  bit           m_done[2], m_ea[2], m_eb[2], m_rv[2], m_rh[2];
  logic [W-1:0] m_ca[2], m_cb[2];
  bit           model_live = 0;
  logic [0:0]   exp_q0[$];
  logic [0:0]   exp_q1[$];

  function automatic bit is_illegal(input logic [W-1:0] x);
    return ($countones(x) == 0) || ($countones(x) == W);
  endfunction

  function automatic bit is_hit(input logic [W-1:0] a, input logic [W-1:0] b);
    return $countones(a ^ b) == W;
  endfunction

  task automatic model_step(input int c);
    int r;
    bit e;
    r = (c == 0) ? R0 : R1;
    e = (c == 0) ? (E0 != 0) : (E1 != 0);
    m_ea[c] = 0; m_eb[c] = 0; m_rv[c] = 0; m_rh[c] = 0;
    if (rst) begin
      m_ph[c] = P_IDLE; m_sa[c] = 0; m_sb[c] = 0; m_rd[c] = 0;
      m_win[c] = 0; m_done[c] = 0; m_ca[c] = '0; m_cb[c] = '0;
      return;
    end
    case (m_ph[c])
      P_IDLE: if (start) begin
        m_ph[c] = P_A; m_sa[c] = 0; m_sb[c] = 0; m_rd[c] = 0;
      end
      P_A: if (ja_valid) begin
        if (is_illegal(ja)) m_ea[c] = 1;
        else begin m_ca[c] = ja; m_ph[c] = P_B; end
      end
      P_B: if (jb_valid) begin
        if (is_illegal(jb)) m_eb[c] = 1;
        else begin
          m_cb[c] = jb; m_ph[c] = P_J; m_rv[c] = 1;
          m_rh[c] = is_hit(m_ca[c], jb);
          if (c == 0) exp_q0.push_back(m_rh[c]);
          else        exp_q1.push_back(m_rh[c]);
        end
      end
      P_J: begin
        if (is_hit(m_ca[c], m_cb[c])) m_sb[c]++;
        else                          m_sa[c]++;
        m_rd[c]++;
        if (m_rd[c] == r || (e && (m_sa[c] > r / 2 || m_sb[c] > r / 2))) begin
          m_ph[c] = P_D; m_done[c] = 1;
          m_win[c] = (m_sa[c] > m_sb[c]) ? 1 : (m_sb[c] > m_sa[c]) ? 2 : 3;
        end else m_ph[c] = P_A;
      end
      P_D: if (start) begin
        m_sa[c] = 0; m_sb[c] = 0; m_rd[c] = 0; m_done[c] = 0; m_win[c] = 0;
        m_ph[c] = P_A;
      end
      default: m_ph[c] = P_IDLE;
    endcase
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (rst) model_live = 1;
  end

  // ---------------- scoreboard: compare every cycle ----------------
  task automatic check_dut(input int c, input logic jar, input logic jbr,
                           input logic ea, input logic eb, input logic rv,
                           input logic rh, input logic dn,
                           input logic [7:0] sa, input logic [7:0] sb,
                           input logic [7:0] rd, input logic [1:0] wn);
    chk(c, "ja_ready", 8'(jar), 8'(m_ph[c] == P_A));
    chk(c, "jb_ready", 8'(jbr), 8'(m_ph[c] == P_B));
    chk(c, "err_a", 8'(ea), 8'(m_ea[c]));
    chk(c, "err_b", 8'(eb), 8'(m_eb[c]));
    chk(c, "res_valid", 8'(rv), 8'(m_rv[c]));
    if (m_rv[c]) chk(c, "res_hit", 8'(rh), 8'(m_rh[c]));
    chk(c, "score_a", sa, 8'(m_sa[c]));
    chk(c, "score_b", sb, 8'(m_sb[c]));
    chk(c, "round", rd, 8'(m_rd[c]));
    chk(c, "done", 8'(dn), 8'(m_done[c]));
    chk(c, "winner", 8'(wn), 8'(m_win[c]));
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      check_dut(0, bus0.ja_ready, bus0.jb_ready, bus0.err_a, bus0.err_b,
                bus0.res_valid, bus0.res_hit, bus0.done, 8'(bus0.score_a),
                8'(bus0.score_b), 8'(bus0.round), bus0.winner);
      check_dut(1, bus1.ja_ready, bus1.jb_ready, bus1.err_a, bus1.err_b,
                bus1.res_valid, bus1.res_hit, bus1.done, 8'(bus1.score_a),
                8'(bus1.score_b), 8'(bus1.round), bus1.winner);
      if (bus0.res_valid === 1'b1) begin
        if (exp_q0.size() == 0) chk(0, "res_hit_queue_empty", 8'd1, 8'd0);
        else chk(0, "res_hit_queue", 8'(bus0.res_hit), 8'(exp_q0.pop_front()));
      end
      if (bus1.res_valid === 1'b1) begin
        if (exp_q1.size() == 0) chk(1, "res_hit_queue_empty", 8'd1, 8'd0);
        else chk(1, "res_hit_queue", 8'(bus1.res_hit), 8'(exp_q1.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(1); rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_ready(input int t, input bit side_b);
    logic r;
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (t == 0) r = side_b ? bus0.jb_ready : bus0.ja_ready;
      else        r = side_b ? bus1.jb_ready : bus1.ja_ready;
      if (r === 1'b1) begin ok = 1; break; end
      tick(1);
    end
    if (!ok) chk(t, side_b ? "wait_jb_ready" : "wait_ja_ready", 8'd0, 8'd1);
  endtask

  task automatic send_a(input int t, input logic [W-1:0] code);
    wait_ready(t, 1'b0);
    ja = code; ja_valid = 1'b1; tick(1); ja_valid = 1'b0;
  endtask

  task automatic send_b(input int t, input logic [W-1:0] code);
    wait_ready(t, 1'b1);
    jb = code; jb_valid = 1'b1; tick(1); jb_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] legal_code();
    return W'($urandom_range(1, (1 << W) - 2));
  endfunction

  // A miss guess reuses A's own code: legal, and never its complement.
  task automatic play_round(input int t, input bit hit);
    logic [W-1:0] a;
    a = legal_code();
    send_a(t, a);
    send_b(t, hit ? ~a : a);
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    logic [W-1:0] rnd;
    rst = 1'b1; start = 1'b0; ja_valid = 1'b0; jb_valid = 1'b0;
    ja = '0; jb = '0;
    tick(2);
    rst = 1'b0;
    chk(0, "reset_round", 8'(bus0.round), 8'd0);
    chk(0, "reset_done", 8'(bus0.done), 8'd0);

    // Legal hit, then illegal codes and a miss.
    pulse_start();
    send_a(0, 3'b001);
    chk(0, "lit_ja_ready_drop", 8'(bus0.ja_ready), 8'd0);
    send_b(0, 3'b110);
    chk(0, "lit_res_valid", 8'(bus0.res_valid), 8'd1);
    chk(0, "lit_res_hit", 8'(bus0.res_hit), 8'd1);
    tick(1);
    chk(0, "lit_score_b", 8'(bus0.score_b), 8'd1);
    chk(0, "lit_score_a", 8'(bus0.score_a), 8'd0);
    chk(0, "lit_round", 8'(bus0.round), 8'd1);
    send_a(0, 3'b111);
    chk(0, "lit_err_a", 8'(bus0.err_a), 8'd1);
    chk(0, "lit_ja_ready_hold", 8'(bus0.ja_ready), 8'd1);
    tick(1);
    chk(0, "lit_err_a_clear", 8'(bus0.err_a), 8'd0);
    send_a(0, 3'b010);
    send_b(0, 3'b000);
    chk(0, "lit_err_b", 8'(bus0.err_b), 8'd1);
    send_b(0, 3'b110);
    chk(0, "lit_miss", 8'(bus0.res_hit), 8'd0);
    tick(1);
    chk(0, "lit_score_a_miss", 8'(bus0.score_a), 8'd1);

    // Early end: three straight hits decide a five-round game.
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) play_round(0, 1'b1);
    tick(1);
    chk(0, "lit_early_done", 8'(bus0.done), 8'd1);
    chk(0, "lit_early_round", 8'(bus0.round), 8'd3);
    chk(0, "lit_early_winner", 8'(bus0.winner), 8'd2);
    chk(0, "lit_early_ja_ready", 8'(bus0.ja_ready), 8'd0);
    chk(1, "lit_noearly_done", 8'(bus1.done), 8'd0);

    // Full four-round game ending in a tie, then a restart.
    do_reset();
    pulse_start();
    play_round(1, 1'b1); play_round(1, 1'b1);
    play_round(1, 1'b0); play_round(1, 1'b0);
    tick(1);
    chk(1, "lit_full_done", 8'(bus1.done), 8'd1);
    chk(1, "lit_full_round", 8'(bus1.round), 8'd4);
    chk(1, "lit_full_winner", 8'(bus1.winner), 8'd3);
    pulse_start();
    chk(1, "lit_restart_ja_ready", 8'(bus1.ja_ready), 8'd1);
    chk(1, "lit_restart_done", 8'(bus1.done), 8'd0);
    chk(1, "lit_restart_round", 8'(bus1.round), 8'd0);

    // Reset in the middle of a game.
    do_reset();
    pulse_start();
    play_round(0, 1'b0); play_round(0, 1'b0);
    send_a(0, legal_code());
    chk(0, "lit_pre_rst_score_a", 8'(bus0.score_a), 8'd2);
    do_reset();
    chk(0, "lit_rst_score_a", 8'(bus0.score_a), 8'd0);
    chk(0, "lit_rst_jb_ready", 8'(bus0.jb_ready), 8'd0);
    ja = 3'b010; ja_valid = 1'b1;
    tick(3);
    chk(0, "lit_idle_ja_ready", 8'(bus0.ja_ready), 8'd0);
    ja_valid = 1'b0;

    // Protocol robustness: stray jb_valid in WAIT_A, start in WAIT_B.
    pulse_start();
    jb = 3'b110; jb_valid = 1'b1; tick(3); jb_valid = 1'b0;
    send_a(0, 3'b001);
    pulse_start();
    send_b(0, 3'b110);
    tick(1);
    chk(0, "lit_proto_round", 8'(bus0.round), 8'd1);
    play_round(0, 1'b0);
    tick(1);
    chk(0, "lit_proto_round2", 8'(bus0.round), 8'd2);

    // Random traffic; about half the B guesses target the latched code.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 11) == 0);
      ja       = W'($urandom_range(0, (1 << W) - 1));
      ja_valid = $urandom_range(0, 1) == 1;
      rnd      = W'($urandom_range(0, (1 << W) - 1));
      jb       = ($urandom_range(0, 1) == 1) ? ~m_ca[i % 2] : rnd;
      jb_valid = $urandom_range(0, 1) == 1;
      tick(1);
    end
    rst = 1'b0; start = 1'b0; ja_valid = 1'b0; jb_valid = 1'b0;
    tick(3);
    chk(0, "queue_drained", 8'(exp_q0.size()), 8'd0);
    chk(1, "queue_drained", 8'(exp_q1.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
